pic_control_param: RTL
======================

Name: pic_control_param

Overview:
Clocked, parametrised successor to the PIC control logic. It sequences ICW1–ICW4 and OCW1–OCW3, latches interrupt requests, resolves priority with fully-nested, rotating and specific-priority modes, and tracks in-service state. It runs the two-pulse INTA acknowledge sequence and produces the vector byte. It sits between the bus/read-write decoder (strobes, data byte) and the IRQ pins and data-bus output driver.

Parameters:
NUM_IRQ, 8, number of request lines; power of two, 2..8
ID_W, 3, log2(NUM_IRQ); must equal $clog2(NUM_IRQ)

Ports:
clk  in  1  single clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
wr_icw1  in  1  one-cycle strobe: ICW1 write
wr_icw2_4  in  1  one-cycle strobe: ICW2/3/4 write, routed by the init FSM
wr_ocw1, wr_ocw2, wr_ocw3  in  1 each  one-cycle OCW strobes
data_in  in  8  internal data bus, sampled with any strobe
irq  in  NUM_IRQ  raw request lines, synchronous to clk
int_ack  in  1  one-cycle strobe per INTA pulse
INT  out  1  interrupt request to the CPU
int_mask  out  NUM_IRQ  current IMR
irr  out  NUM_IRQ  request register
isr  out  NUM_IRQ  in-service register
vector_out  out  8  {icw2_base[7:ID_W], granted id}
vector_valid  out  1  one-cycle qualifier on the 2nd INTA
read_data  out  8  zero-extended irr or isr, selected by OCW3
cascade_cfg  out  8  ICW3 value
init_done  out  1  high in READY

Behaviour:
- Reset values: INT=0, int_mask=all 1, irr=0, isr=0, vector_out=0, vector_valid=0, read_data=irr (0), cascade_cfg=0, init_done=0. Lowest-priority pointer=NUM_IRQ-1. AEOI=0, auto-rotate=0, LTIM=0, read-select=IRR. Init FSM=UNINIT, ack FSM=IDLE.
- Strobe priority if several fire in one cycle: icw1 > icw2_4 > ocw1 > ocw2 > ocw3. Only the winner acts.
- Init FSM states: UNINIT, ICW2, ICW3, ICW4, READY.
  - wr_icw1 from any state → ICW2. It latches LTIM=d[3], SNGL=d[1], IC4=d[0]. It clears isr, irr and cascade_cfg, sets int_mask all 1, pointer=NUM_IRQ-1, AEOI=0, auto-rotate=0, and aborts the ack FSM to IDLE.
  - ICW2 strobe: base=d[7:ID_W]. Next state is ICW3 if SNGL=0, else ICW4 if IC4=1, else READY.
  - ICW3 strobe: cascade_cfg=d. Next state is ICW4 if IC4, else READY.
  - ICW4 strobe: AEOI=d[1]. Next state is READY.
  - wr_icw2_4 in UNINIT or READY is ignored.
  - OCW strobes are ignored outside READY. INT is held 0 outside READY.
- Request latch:
  - Edge mode (LTIM=0): irr bit sets on a 0→1 of irq versus the previous-cycle sample. It clears on ACK1 grant of that bit. Set wins over clear in the same cycle.
  - Level mode: irr = irq each cycle. irr is not masked. Masking applies only to the resolver.
- Resolver: candidates = irr & ~int_mask. Priority order starts at pointer+1 (mod NUM_IRQ) and ends at pointer.
  - Winner = first candidate in that order.
  - Fully nested: the winner counts only if it is strictly higher in priority than the highest set isr bit, or isr=0.
  - INT is registered: it goes 1 the cycle after a qualifying winner exists, and drops 1 cycle after the condition goes away.
- Ack FSM states: IDLE, ACK1, ACK2.
  - IDLE + int_ack → ACK1. In that cycle, grant_id=winner and the isr bit is set (edge mode also clears the irr bit).
  - If there is no winner (spurious), grant_id=NUM_IRQ-1 and isr is unchanged.
  - ACK1 + int_ack → ACK2. vector_out={base,grant_id} and vector_valid=1 for exactly this cycle.
  - If AEOI, the isr bit clears in the same cycle; if auto-rotate is also set, pointer=grant_id.
  - ACK2 → IDLE unconditionally next cycle.
- OCW1: int_mask=d[NUM_IRQ-1:0].
- OCW2 on d[7:5], L=d[ID_W-1:0]:
  - 001: clear the highest-priority set isr bit.
  - 011: clear isr[L].
  - 101: as 001, then pointer=cleared id.
  - 111: clear isr[L], pointer=L.
  - 110: pointer=L.
  - 100: auto-rotate=1.
  - 000: auto-rotate=0.
  - 010: no-op.
  - Non-specific EOI with isr=0 does nothing.
- EOI and ACK1 set in the same cycle: the clear is computed on the old isr, then the set is applied; both take effect.
- OCW3: if d[1]=1, read-select=d[0] (1=ISR, 0=IRR); d[1]=0 leaves it unchanged. read_data is combinational from the current register.
- Reset mid-sequence returns every register to its reset value immediately.

Test Plan:
- Reset, ICW1=0x13, ICW2=0x40, ICW4=0x01, OCW1=0x00 → init_done=1 after ICW4, cascade_cfg=0.
- Pulse irq[3], then irq[1] 2 cycles later, then two int_ack → INT rises 1 cycle after the edge; isr=0x02; vector_out=0x41 with one-cycle vector_valid; irr=0x08.
- With isr=0x02, raise irq[5] → INT stays 0. OCW2=0x20 → isr=0; INT=1 next cycle.
- ICW4=0x03, OCW2=0x80, irq[2] acked → isr stays 0 after ACK2 and pointer=2. Simultaneous irq[2],irq[3] → irq[3] granted first.
- Two int_ack with no request → vector_out={base,7}, isr unchanged. ICW1 issued between ACK1 and ACK2 → ack FSM IDLE, no vector_valid.
- OCW3=0x0B → read_data=isr. OCW3=0x08 → selection unchanged. Level mode: irq[0] held → irr[0] stays 1 after ACK1.

Source files
------------

// File: rtl/pic_control_param.sv
// pic_control_param: clocked PIC controller with ICW/OCW sequencing, IRR/ISR tracking, rotating priority and INTA vectoring.
// Ports: clk/reset; wr_icw1, wr_icw2_4, wr_ocw1..3 strobes with data_in; irq request lines; int_ack INTA pulses;
// INT to CPU; int_mask/irr/isr register views; vector_out/vector_valid on the 2nd INTA; read_data (IRR or ISR);
// cascade_cfg (ICW3); init_done in READY.
module pic_control_param #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_icw1,
  input  logic               wr_icw2_4,
  input  logic               wr_ocw1,
  input  logic               wr_ocw2,
  input  logic               wr_ocw3,
  input  logic [7:0]         data_in,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               int_ack,
  output logic               INT,
  output logic [NUM_IRQ-1:0] int_mask,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] isr,
  output logic [7:0]         vector_out,
  output logic               vector_valid,
  output logic [7:0]         read_data,
  output logic [7:0]         cascade_cfg,
  output logic               init_done
);
  localparam logic [2:0] S_UNINIT = 3'd0, S_ICW2 = 3'd1, S_ICW3 = 3'd2, S_ICW4 = 3'd3, S_READY = 3'd4;
  localparam logic [1:0] A_IDLE = 2'd0, A_ACK1 = 2'd1, A_ACK2 = 2'd2;
  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_IRQ - 1);
  logic [2:0] init_st;
  logic [1:0] ack_st;
  logic ltim, sngl, ic4, aeoi, arot, rsel;
  logic [7-ID_W:0] base;
  logic [ID_W-1:0] ptr, ptr_n, grant_id, win_id, win_rk, isr_id, isr_rk, clr_id;
  logic [NUM_IRQ-1:0] irq_q, cand, isr_clr, isr_set, isr_n, irr_n;
  logic win_v, isr_v, qual, ready;
  logic s_icw24, s_ocw1, s_ocw2, s_ocw3, ack1_go, ack2_go, eoi_ns, eoi_sp;
  logic [2:0] op;
  logic [ID_W-1:0] lvl;
  assign ready = init_st == S_READY;
  assign init_done = ready;
  // Strobe priority: icw1 > icw2_4 > ocw1 > ocw2 > ocw3; an ignored higher strobe still blocks lower ones.
  assign s_icw24 = !wr_icw1 && wr_icw2_4;
  assign s_ocw1 = !wr_icw1 && !wr_icw2_4 && wr_ocw1 && ready;
  assign s_ocw2 = !wr_icw1 && !wr_icw2_4 && !wr_ocw1 && wr_ocw2 && ready;
  assign s_ocw3 = !wr_icw1 && !wr_icw2_4 && !wr_ocw1 && !wr_ocw2 && wr_ocw3 && ready;
  assign ack1_go = !wr_icw1 && ack_st == A_IDLE && int_ack;
  assign ack2_go = !wr_icw1 && ack_st == A_ACK1 && int_ack;
  assign cand = irr & ~int_mask;
  assign op = data_in[7:5];
  assign lvl = data_in[ID_W-1:0];
  assign read_data = rsel ? 8'(isr) : 8'(irr);
  // Scan from lowest to highest priority so the last hit is the highest; rank 0 is the slot after ptr.
  always_comb begin
    win_v = 1'b0;
    win_id = LAST;
    win_rk = '0;
    isr_v = 1'b0;
    isr_id = '0;
    isr_rk = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (cand[ptr + ID_W'(k + 1)]) begin
        win_v = 1'b1;
        win_id = ptr + ID_W'(k + 1);
        win_rk = ID_W'(k);
      end
      if (isr[ptr + ID_W'(k + 1)]) begin
        isr_v = 1'b1;
        isr_id = ptr + ID_W'(k + 1);
        isr_rk = ID_W'(k);
      end
    end
  end
  assign qual = win_v && (!isr_v || win_rk < isr_rk);
  assign eoi_ns = s_ocw2 && (op == 3'b001 || op == 3'b101) && isr_v;
  assign eoi_sp = s_ocw2 && (op == 3'b011 || op == 3'b111);
  assign clr_id = eoi_ns ? isr_id : lvl;
  // Clears are taken from the old ISR, then the ACK1 set is applied on top.
  always_comb begin
    isr_clr = '0;
    isr_set = '0;
    if (eoi_ns || eoi_sp) isr_clr[clr_id] = 1'b1;
    if (ack2_go && aeoi) isr_clr[grant_id] = 1'b1;
    if (ack1_go && qual) isr_set[win_id] = 1'b1;
  end
  assign isr_n = (isr & ~isr_clr) | isr_set;
  assign irr_n = ltim ? irq : ((irr & ~isr_set) | (irq & ~irq_q));
  always_comb begin
    ptr_n = (ack2_go && aeoi && arot) ? grant_id : ptr;
    if ((eoi_ns && op == 3'b101) || (s_ocw2 && (op == 3'b111 || op == 3'b110)))
      ptr_n = op == 3'b101 ? isr_id : lvl;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_st <= S_UNINIT;
      ack_st <= A_IDLE;
      {ltim, sngl, ic4, aeoi, arot, rsel} <= '0;
      base <= '0;
      ptr <= LAST;
      grant_id <= '0;
      irq_q <= '0;
      INT <= 1'b0;
      int_mask <= '1;
      irr <= '0;
      isr <= '0;
      vector_out <= '0;
      vector_valid <= 1'b0;
      cascade_cfg <= '0;
    end else begin
      irq_q <= irq;
      INT <= ready && qual && !wr_icw1;
      vector_valid <= ack2_go;
      if (ack2_go) vector_out <= {base, grant_id};
      if (wr_icw1) begin
        init_st <= S_ICW2;
        ltim <= data_in[3];
        sngl <= data_in[1];
        ic4 <= data_in[0];
        isr <= '0;
        irr <= '0;
        cascade_cfg <= '0;
        int_mask <= '1;
        ptr <= LAST;
        aeoi <= 1'b0;
        arot <= 1'b0;
        ack_st <= A_IDLE;
      end else begin
        irr <= irr_n;
        isr <= isr_n;
        ptr <= ptr_n;
        ack_st <= ack1_go ? A_ACK1 : ack2_go ? A_ACK2 : ack_st == A_ACK2 ? A_IDLE : ack_st;
        if (ack1_go) grant_id <= qual ? win_id : LAST;
        if (s_icw24 && init_st == S_ICW2) begin
          base <= data_in[7:ID_W];
          init_st <= !sngl ? S_ICW3 : ic4 ? S_ICW4 : S_READY;
        end
        if (s_icw24 && init_st == S_ICW3) begin
          cascade_cfg <= data_in;
          init_st <= ic4 ? S_ICW4 : S_READY;
        end
        if (s_icw24 && init_st == S_ICW4) begin
          aeoi <= data_in[1];
          init_st <= S_READY;
        end
        if (s_ocw1) int_mask <= data_in[NUM_IRQ-1:0];
        if (s_ocw2 && op == 3'b100) arot <= 1'b1;
        if (s_ocw2 && op == 3'b000) arot <= 1'b0;
        if (s_ocw3 && data_in[1]) rsel <= data_in[0];
      end
    end
  end
endmodule
